// File: rtl/mcu_pkg.sv
// Shared constants and state encoding for the multi-cycle MCU control path.
// Latency: none (declarations only).
// Backpressure: n/a.
package mcu_pkg;

   // Opcode map (IR[15:12]); 0x0-0x7 are R-type, 0xD/0xE are illegal
   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_LW   = 4'h9;
   localparam logic [3:0] OP_SW   = 4'hA;
   localparam logic [3:0] OP_BEQ  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   localparam logic [1:0] PC_SRC_INC = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_EXEC_I   = 4'd3,
      ST_MEM_ADDR = 4'd4,
      ST_MEM_RD   = 4'd5,
      ST_MEM_WR   = 4'd6,
      ST_WB_ALU   = 4'd7,
      ST_WB_MEM   = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JUMP     = 4'd10,
      ST_HALT     = 4'd11,
      ST_ERROR    = 4'd12
   } state_t;

   // R-type opcodes occupy the lower half of the opcode space
   function automatic logic is_rtype(input logic [3:0] op);
      return ~op[3];
   endfunction

endpackage

// File: rtl/mcu_mem_wait_timer.sv
// Counts data-memory wait cycles and flags a timeout at WAIT_LIMIT.
// Latency: timeout is combinational on the cycle the limit is reached.
// Backpressure: none; mem_ready on the limit cycle suppresses timeout.
module mcu_mem_wait_timer #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic clk,
   input  logic clear,
   input  logic restart,
   input  logic active,
   input  logic mem_ready,
   output logic timeout
);

   localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

   logic [CW-1:0] cnt;

   // Counter restarts on wait-state entry and counts cycles without mem_ready (saturating)
   always_ff @(posedge clk) begin
      if (clear || restart) begin
         cnt <= '0;
      end else if (active && !mem_ready && (cnt != '1)) begin
         cnt <= cnt + CW'(1);
      end
   end

   // This cycle would be the WAIT_LIMIT-th unanswered one; WAIT_LIMIT=0 never times out
   assign timeout = (WAIT_LIMIT != 0) && active && !mem_ready && (int'(cnt) == WAIT_LIMIT - 1);

endmodule

// File: rtl/mcu_multi_cycle_ctrl.sv
// Moore sequencer driving the shared MCU datapath across fetch/decode/exec/mem/wb steps.
// Latency: R/ADDI 4, SW 4+waits, LW 5+waits, BEQ/JMP 3, illegal 2 cycles.
// Backpressure: stalls in MEM_RD/MEM_WR until mem_ready, ERROR after WAIT_LIMIT waits.
module mcu_multi_cycle_ctrl
   import mcu_pkg::*;
#(
   parameter int OPC_W      = 4,
   parameter int CNT_W      = 16,
   parameter int WAIT_LIMIT = 15
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [OPC_W-1:0] opcode,
   input  logic             zero_flag,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             alu_src,
   output logic [2:0]       alu_op,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             halted,
   output logic             error,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state
);

   state_t     st;
   logic [3:0] op;
   logic       timeout;
   logic       retire;
   logic       in_wait;

   assign op      = opcode[OPC_W-1:OPC_W-4];
   assign state   = st;
   assign in_wait = (st == ST_MEM_RD) || (st == ST_MEM_WR);

   // An instruction completes when leaving any of its final states
   assign retire = (st == ST_WB_ALU) || (st == ST_WB_MEM) || (st == ST_BRANCH) ||
                   (st == ST_JUMP) || ((st == ST_MEM_WR) && mem_ready);

   mcu_mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
      .clk       (clk),
      .clear     (clear),
      .restart   (st == ST_MEM_ADDR),
      .active    (in_wait),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   // State sequencing and saturating retired-instruction count
   always_ff @(posedge clk) begin
      if (clear) begin
         st      <= ST_FETCH;
         retired <= '0;
      end else begin
         case (st)
            ST_FETCH:  st <= ST_DECODE;
            ST_DECODE: begin
               if (is_rtype(op)) begin
                  st <= ST_EXEC_R;
               end else begin
                  case (op)
                     OP_ADDI:      st <= ST_EXEC_I;
                     OP_LW, OP_SW: st <= ST_MEM_ADDR;
                     OP_BEQ:       st <= ST_BRANCH;
                     OP_JMP:       st <= ST_JUMP;
                     OP_HALT:      st <= ST_HALT;
                     default:      st <= ST_FETCH;
                  endcase
               end
            end
            ST_EXEC_R, ST_EXEC_I: st <= ST_WB_ALU;
            ST_MEM_ADDR: st <= (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
               if (mem_ready)    st <= ST_WB_MEM;
               else if (timeout) st <= ST_ERROR;
            end
            ST_MEM_WR: begin
               if (mem_ready)    st <= ST_FETCH;
               else if (timeout) st <= ST_ERROR;
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: st <= ST_FETCH;
            ST_HALT, ST_ERROR: st <= st;
            default: st <= ST_FETCH;
         endcase
         if (retire && (retired != '1)) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

   // Control decode from state and opcode; clear kills every strobe in the same cycle
   always_comb begin
      pc_write   = 1'b0;
      pc_src     = PC_SRC_INC;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      case (st)
         ST_FETCH: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
         end
         ST_EXEC_R: alu_op = op[2:0];
         ST_EXEC_I: alu_src = 1'b1;
         ST_WB_ALU: begin
            reg_write = 1'b1;
            reg_dst   = is_rtype(op);
            alu_src   = (op == OP_ADDI);
            alu_op    = is_rtype(op) ? op[2:0] : ALU_ADD;
         end
         ST_MEM_ADDR: alu_src = 1'b1;
         ST_MEM_RD: begin
            alu_src  = 1'b1;
            mem_read = 1'b1;
         end
         ST_MEM_WR: begin
            alu_src   = 1'b1;
            mem_write = 1'b1;
         end
         ST_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         ST_BRANCH: begin
            alu_op   = ALU_SUB;
            pc_src   = PC_SRC_BR;
            pc_write = zero_flag;
         end
         ST_JUMP: begin
            pc_src   = PC_SRC_JMP;
            pc_write = 1'b1;
         end
         default: ;
      endcase
      if (clear) begin
         pc_write   = 1'b0;
         pc_src     = PC_SRC_INC;
         ir_write   = 1'b0;
         reg_dst    = 1'b0;
         alu_src    = 1'b0;
         alu_op     = ALU_ADD;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         mem_to_reg = 1'b0;
         reg_write  = 1'b0;
      end
   end

   assign halted = (st == ST_HALT) || (st == ST_ERROR);
   assign error  = (st == ST_ERROR);

endmodule

// File: doc/mcu_multi_cycle_ctrl.md
Name: mcu_multi_cycle_ctrl

Overview:
Multi-cycle sequencer for the 16-bit MCU datapath. It replaces the single-cycle combinational control decoder with a Moore FSM, so the register file, ALU and data memory are shared across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps. It accepts a ready handshake from data memory, retires instructions into a counter, and detects HALT and memory-timeout conditions.

Parameters:
OPC_W, 4, opcode width (INSTR[15:12])
CNT_W, 16, retired-instruction counter width
WAIT_LIMIT, 15, maximum mem_ready wait cycles before ERROR; 0 = wait forever

Ports:
clk  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
opcode  in  OPC_W  IR[15:12], valid from DECODE onward
zero_flag  in  1  ALU E (equal) flag, combinational from datapath
mem_ready  in  1  data memory access complete this cycle
pc_write  out  1  PC register load enable
pc_src  out  2  00 PC+1, 01 branch target, 10 jump {PC[15:12],IR[11:0]}
ir_write  out  1  instruction register load enable
reg_dst  out  1  0 = IR[7:4], 1 = IR[3:0] write address
alu_src  out  1  0 = data2, 1 = sign-extended IR[3:0]
alu_op  out  3  ALU operation
mem_read  out  1  data memory read strobe
mem_write  out  1  data memory write strobe
mem_to_reg  out  1  writeback select, 1 = memory data
reg_write  out  1  register file write enable
halted  out  1  FSM is in HALT or ERROR
error  out  1  FSM is in ERROR (memory timeout)
retired  out  CNT_W  completed-instruction count
state  out  4  current state encoding, for debug

Behaviour:
- Opcode map: 0x0–0x7 R-type, alu_op = opcode[2:0]. 0x8 ADDI. 0x9 LW. 0xA SW. 0xB BEQ. 0xC JMP. 0xF HALT. 0xD and 0xE are illegal and behave as NOP.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT, ERROR.
- Outputs are a pure function of the registered state and opcode. No output is registered separately. Any strobe not listed for a state is 0.
- FETCH: ir_write=1, pc_write=1, pc_src=00. Next state is DECODE.
- DECODE: no strobes. Next state by opcode:
  - R-type → EXEC_R; ADDI → EXEC_I
  - LW/SW → MEM_ADDR; BEQ → BRANCH; JMP → JUMP
  - HALT → HALT; illegal → FETCH, not retired
- EXEC_R: alu_src=0, alu_op=opcode[2:0]. Next state is WB_ALU.
- EXEC_I: alu_src=1, alu_op=000. Next state is WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0, ALU controls held from the previous EXEC state. reg_dst=1 for R-type, 0 for ADDI. Next state is FETCH.
- MEM_ADDR: alu_src=1, alu_op=000. Next state is MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1 and the address controls held. On mem_ready=1, next state is WB_MEM; otherwise stay.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0. Next state is FETCH.
- MEM_WR: mem_write=1 held until mem_ready=1, then FETCH.
- BRANCH: alu_src=0, alu_op=001 (SUB), pc_src=01, pc_write=zero_flag. Next state is FETCH.
- JUMP: pc_src=10, pc_write=1. Next state is FETCH.
- HALT and ERROR: terminal. All strobes are 0 and halted=1. Only clear exits them.
- Latency in cycles, including FETCH:
  - R-type/ADDI 4; SW 4 + extra waits; LW 5 + extra waits
  - BEQ 3; JMP 3; illegal 2
- Wait counter:
  - Clears on entry to MEM_RD/MEM_WR and increments each cycle mem_ready=0.
  - If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT with mem_ready still 0, next state is ERROR. error=1 and the access strobe drops.
  - mem_ready=1 on the limit cycle wins; the access completes normally.
- retired:
  - Increments by 1 on the cycle leaving WB_ALU, WB_MEM, BRANCH, JUMP, or MEM_WR with mem_ready=1.
  - Saturates at all-ones. HALT and illegal opcodes do not count.
- clear=1:
  - All strobes are forced to 0 combinationally that cycle.
  - Next state is FETCH; retired, wait counter, halted and error return to 0.
  - Effective mid-instruction, including mid-wait. Any pending memory access is abandoned with no strobe after the edge.
- mem_ready outside MEM_RD/MEM_WR is ignored.

Decomposition:
- Shared package mcu_pkg holds:
  - opcode constants (OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HALT)
  - ALU op constants (ALU_ADD=000, ALU_SUB=001)
  - PC_SRC constants
  - the state enumeration (4-bit localparams)
- One sub-module, mcu_mem_wait_timer, contains the wait counter and limit compare, with outputs timeout and a clear-on-entry input. The FSM stays in the top module.

Test Plan:
- R-type: clear for 2 cycles, then opcode=0x2 with mem_ready=0 → strobes low during clear; states FETCH→DECODE→EXEC_R→WB_ALU; reg_write=1, reg_dst=1, alu_op=010 on cycle 4; retired=1.
- LW with wait: opcode=0x9, mem_ready low for 3 MEM_RD cycles then high → mem_read=1 for 4 cycles; WB_MEM has reg_write=1, mem_to_reg=1; total 8 cycles; retired increments once.
- Timeout: opcode=0xA, WAIT_LIMIT=15, mem_ready held 0 → mem_write drops after 15 wait cycles; error=1, halted=1; retired unchanged; a later clear returns to FETCH with error=0.
- BEQ: opcode=0xB with zero_flag=1, then again with zero_flag=0 → BRANCH shows pc_src=01 with pc_write=1, then pc_write=0; alu_op=001; each takes 3 cycles and retires.
- HALT and illegal: opcode=0xD → returns to FETCH after 2 cycles, not retired. Then opcode=0xF → halted=1 indefinitely, all strobes 0, ir_write never reasserts.
- Saturation: CNT_W=4, 17 JMPs (opcode=0xC, pc_src=10) → retired sticks at 15.
